// File: rtl/load_align_unit_if.sv
// Handshake bundle for load_align_unit: request, memory read and response.
// master: the requester/memory side; slave: the alignment unit.
interface load_align_unit_if #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [2:0]        req_funct3;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rvalid;
    logic [XLEN-1:0]   mem_rdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_data;
    logic              resp_err;

    modport master (
        output req_valid, req_addr, req_funct3, mem_rvalid, mem_rdata,
        input  req_ready, mem_req, mem_addr, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_funct3, mem_rvalid, mem_rdata,
        output req_ready, mem_req, mem_addr, resp_valid, resp_data, resp_err
    );
endinterface

// File: rtl/load_align_unit.sv
// Load alignment/extension unit: issues one or two aligned word reads,
// merges beats across a word boundary and sign/zero-extends the result.
// Ports: clk, reset (async, active-high), bus (load_align_unit_if.slave):
//   req_valid/req_ready/req_addr/req_funct3 - load request
//   mem_req/mem_addr/mem_rvalid/mem_rdata   - aligned data-memory reads
//   resp_valid/resp_data/resp_err           - one-cycle extended result
// Option: define LOAD_MISALIGNED_SPLIT_EN to split word-crossing loads into
// two beats; without it a crossing load returns an error response.
module load_align_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    load_align_unit_if.slave bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {IDLE, RD0, RD1, RESP} state_t;

    state_t           state;
    logic [OFF_W-1:0] off_q;
    logic [1:0]       sz_q;
    logic             uns_q;
`ifdef LOAD_MISALIGNED_SPLIT_EN
    logic             cross_q;
    logic [XLEN-1:0]  lo_q;
`endif

    logic [OFF_W-1:0] req_off;
    logic [4:0]       req_end;
    logic             req_cross;
    logic             req_legal;
    logic             req_bad;

    assign req_off   = bus.req_addr[OFF_W-1:0];
    assign req_end   = 5'(req_off) + (5'd1 << bus.req_funct3[1:0]);
    assign req_cross = req_end > 5'(NB);

    always_comb begin
        unique case (bus.req_funct3)
            3'b000, 3'b001, 3'b010,
            3'b100, 3'b101: req_legal = 1'b1;
            3'b011, 3'b110: req_legal = (XLEN == 64);
            default:        req_legal = 1'b0;
        endcase
    end

`ifdef LOAD_MISALIGNED_SPLIT_EN
    assign req_bad = !req_legal;
`else
    assign req_bad = !req_legal || req_cross;
`endif

    logic [XLEN-1:0] beat_lo;
    logic [XLEN-1:0] beat_hi;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep_mask;
    logic [XLEN-1:0] top_bit;
    logic [XLEN-1:0] merged;
    logic [6:0]      nbits;
    logic            sign;

    // The result is built straight from the arriving beat so it can be
    // registered on the same edge that captures mem_rdata.
`ifdef LOAD_MISALIGNED_SPLIT_EN
    assign beat_lo = (state == RD1) ? lo_q : bus.mem_rdata;
    assign beat_hi = (state == RD1) ? bus.mem_rdata : '0;
`else
    assign beat_lo = bus.mem_rdata;
    assign beat_hi = '0;
`endif

    assign shifted   = XLEN'({beat_hi, beat_lo} >> {off_q, 3'b000});
    assign nbits     = 7'd8 << sz_q;
    // Shifting by XLEN yields 0, so full-width loads get an all-ones mask.
    assign keep_mask = ~({XLEN{1'b1}} << nbits);
    assign top_bit   = keep_mask & ~(keep_mask >> 1);
    assign sign      = (|(shifted & top_bit)) & ~uns_q;
    assign merged    = (shifted & keep_mask) | ({XLEN{sign}} & ~keep_mask);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            off_q          <= '0;
            sz_q           <= '0;
            uns_q          <= 1'b0;
`ifdef LOAD_MISALIGNED_SPLIT_EN
            cross_q        <= 1'b0;
            lo_q           <= '0;
`endif
            bus.req_ready  <= 1'b0;
            bus.mem_req    <= 1'b0;
            bus.mem_addr   <= '0;
            bus.resp_valid <= 1'b0;
            bus.resp_data  <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_ready && bus.req_valid) begin
                        bus.req_ready <= 1'b0;
                        off_q         <= req_off;
                        sz_q          <= bus.req_funct3[1:0];
                        uns_q         <= bus.req_funct3[2];
`ifdef LOAD_MISALIGNED_SPLIT_EN
                        cross_q       <= req_cross;
`endif
                        if (req_bad) begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b1;
                            bus.resp_data  <= '0;
                        end else begin
                            state        <= RD0;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= {bus.req_addr[ADDR_W-1:OFF_W],
                                             {OFF_W{1'b0}}};
                        end
                    end
                end
                RD0: begin
                    // rvalid is not looked at during the strobe cycle.
                    if (bus.mem_req) begin
                        bus.mem_req <= 1'b0;
                    end else if (bus.mem_rvalid) begin
`ifdef LOAD_MISALIGNED_SPLIT_EN
                        lo_q <= bus.mem_rdata;
                        if (cross_q) begin
                            state        <= RD1;
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= bus.mem_addr + ADDR_W'(NB);
                        end else begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b0;
                            bus.resp_data  <= merged;
                        end
`else
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_data  <= merged;
`endif
                    end
                end
`ifdef LOAD_MISALIGNED_SPLIT_EN
                RD1: begin
                    if (bus.mem_req) begin
                        bus.mem_req <= 1'b0;
                    end else if (bus.mem_rvalid) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b0;
                        bus.resp_data  <= merged;
                    end
                end
`endif
                RESP: begin
                    state          <= IDLE;
                    bus.req_ready  <= 1'b1;
                    bus.resp_valid <= 1'b0;
                    bus.resp_err   <= 1'b0;
                    bus.resp_data  <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_align_unit.sv
// Directed self-checking bench for load_align_unit (32- and 64-bit builds).
// Expected values are hand-computed per vector.
module tb_load_align_unit;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    load_align_unit_if #(.XLEN(32), .ADDR_W(32)) b32 ();
    load_align_unit_if #(.XLEN(64), .ADDR_W(32)) b64 ();

    load_align_unit #(.XLEN(32), .ADDR_W(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (b32)
    );

    load_align_unit #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk   (clk),
        .reset (reset),
        .bus   (b64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_rv(input bit w, input logic v, input logic [63:0] d);
        if (w) begin
            b64.mem_rvalid = v;
            b64.mem_rdata  = d;
        end else begin
            b32.mem_rvalid = v;
            b32.mem_rdata  = d[31:0];
        end
    endtask

    // One load: beat n is answered k cycles after its mem_req.
    task automatic do_load(input bit w, input string tag,
                           input logic [31:0] addr, input logic [2:0] f3,
                           input logic [63:0] d0, input logic [63:0] d1,
                           input int k, input logic [63:0] exp_d,
                           input logic exp_e, input int exp_lat,
                           input int exp_n, input logic [31:0] exp_a0,
                           input logic [31:0] exp_a1);
        int          cnt;
        int          n;
        int          lat;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [63:0] rd;
        logic        re;
        logic        mreq;
        logic [31:0] maddr;
        logic        rv;
        cnt = 0;
        n   = 0;
        lat = 0;
        a0  = '0;
        a1  = '0;
        rd  = '0;
        re  = 1'b0;
        chk({tag, "_ready"}, w ? b64.req_ready : b32.req_ready, 1);
        if (w) begin
            b64.req_valid  = 1'b1;
            b64.req_addr   = addr;
            b64.req_funct3 = f3;
        end else begin
            b32.req_valid  = 1'b1;
            b32.req_addr   = addr;
            b32.req_funct3 = f3;
        end
        tick();
        b32.req_valid = 1'b0;
        b64.req_valid = 1'b0;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            drive_rv(w, 1'b0, '0);
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) drive_rv(w, 1'b1, (n == 1) ? d0 : d1);
            end
            mreq  = w ? b64.mem_req  : b32.mem_req;
            maddr = w ? b64.mem_addr : b32.mem_addr;
            rv    = w ? b64.resp_valid : b32.resp_valid;
            if (mreq) begin
                if (n == 0) a0 = maddr;
                else a1 = maddr;
                n++;
                cnt = k;
            end
            if (rv) begin
                lat = c;
                rd  = w ? b64.resp_data : {32'h0, b32.resp_data};
                re  = w ? b64.resp_err : b32.resp_err;
            end
            if (lat == 0) tick();
        end
        drive_rv(w, 1'b0, '0);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_nreq"}, n, exp_n);
        if (exp_n >= 1) chk({tag, "_a0"}, a0, exp_a0);
        if (exp_n >= 2) chk({tag, "_a1"}, a1, exp_a1);
        chk({tag, "_data"}, rd, exp_d);
        chk({tag, "_err"}, re, exp_e);
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        b32.req_valid = 1'b0; b32.req_addr = '0; b32.req_funct3 = '0;
        b32.mem_rvalid = 1'b0; b32.mem_rdata = '0;
        b64.req_valid = 1'b0; b64.req_addr = '0; b64.req_funct3 = '0;
        b64.mem_rvalid = 1'b0; b64.mem_rdata = '0;
        tick();
        tick();
        chk("rst_ready", b32.req_ready, 0);
        chk("rst_mreq", b32.mem_req, 0);
        chk("rst_maddr", b32.mem_addr, 0);
        chk("rst_rv", b32.resp_valid, 0);
        chk("rst_rdata", b32.resp_data, 0);
        chk("rst_rv64", b64.resp_valid, 0);
        reset = 1'b0;
        tick();
        chk("rel_ready", b32.req_ready, 1);

        do_load(0, "lb", 32'h103, 3'b000, 64'h80AABBCC, 0, 1,
                64'hFFFFFF80, 0, 3, 1, 32'h100, 0);
        do_load(0, "lhu", 32'h102, 3'b101, 64'hBEEF1234, 0, 3,
                64'h0000BEEF, 0, 5, 1, 32'h100, 0);
        do_load(0, "lh", 32'h101, 3'b001, 64'h00876500, 0, 2,
                64'hFFFF8765, 0, 4, 1, 32'h100, 0);
        do_load(0, "lbu", 32'h102, 3'b100, 64'h00F00000, 0, 1,
                64'h000000F0, 0, 3, 1, 32'h100, 0);
        do_load(0, "lw", 32'h200, 3'b010, 64'hDEADBEEF, 0, 1,
                64'hDEADBEEF, 0, 3, 1, 32'h200, 0);
`ifdef LOAD_MISALIGNED_SPLIT_EN
        do_load(0, "lwsplit", 32'h1FE, 3'b010, 64'h22115566,
                64'h77884433, 1, 64'h44332211, 0, 5, 2, 32'h1FC, 32'h200);
`else
        do_load(0, "lwcross", 32'h1FE, 3'b010, 64'h22115566,
                64'h77884433, 1, 0, 1, 1, 0, 0, 0);
`endif
        do_load(0, "ill111", 32'h100, 3'b111, 0, 0, 1, 0, 1, 1, 0, 0, 0);
        do_load(0, "ill011", 32'h100, 3'b011, 0, 0, 1, 0, 1, 1, 0, 0, 0);

        // Backpressure: second request held while busy.
        chk("bp_ready0", b32.req_ready, 1);
        b32.req_valid  = 1'b1;
        b32.req_addr   = 32'h100;
        b32.req_funct3 = 3'b000;
        tick();
        b32.req_addr   = 32'h101;
        b32.req_funct3 = 3'b100;
        chk("bp_busy", b32.req_ready, 0);
        chk("bp_mreq", b32.mem_req, 1);
        chk("bp_maddr", b32.mem_addr, 32'h100);
        b32.mem_rvalid = 1'b1;
        b32.mem_rdata  = 32'h000000FF;
        tick();
        b32.mem_rdata  = 32'h00007F81;
        chk("bp_norv", b32.resp_valid, 0);
        tick();
        b32.mem_rvalid = 1'b0;
        chk("bp_rv1", b32.resp_valid, 1);
        chk("bp_d1", b32.resp_data, 32'hFFFFFF81);
        chk("bp_e1", b32.resp_err, 0);
        chk("bp_busy2", b32.req_ready, 0);
        tick();
        chk("bp_ready1", b32.req_ready, 1);
        chk("bp_rvoff", b32.resp_valid, 0);
        tick();
        b32.req_valid = 1'b0;
        chk("bp_mreq2", b32.mem_req, 1);
        chk("bp_ready2", b32.req_ready, 0);
        tick();
        b32.mem_rvalid = 1'b1;
        b32.mem_rdata  = 32'h00007F81;
        tick();
        b32.mem_rvalid = 1'b0;
        chk("bp_rv2", b32.resp_valid, 1);
        chk("bp_d2", b32.resp_data, 32'h0000007F);
        tick();

        // Stray rvalid while idle.
        b32.mem_rvalid = 1'b1;
        b32.mem_rdata  = 32'h12345678;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stray_rv", b32.resp_valid, 0);
            chk("stray_mreq", b32.mem_req, 0);
        end
        b32.mem_rvalid = 1'b0;
        chk("stray_ready", b32.req_ready, 1);

        // Reset while waiting in RD0.
        b32.req_valid  = 1'b1;
        b32.req_addr   = 32'h300;
        b32.req_funct3 = 3'b010;
        tick();
        b32.req_valid = 1'b0;
        chk("ab_mreq", b32.mem_req, 1);
        tick();
        reset = 1'b1;
        #1;
        chk("ab_ready", b32.req_ready, 0);
        chk("ab_mreq0", b32.mem_req, 0);
        chk("ab_maddr", b32.mem_addr, 0);
        chk("ab_rv", b32.resp_valid, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();
        chk("ab_ready1", b32.req_ready, 1);
        b32.mem_rvalid = 1'b1;
        b32.mem_rdata  = 32'hCAFEF00D;
        tick();
        chk("ab_late1", b32.resp_valid, 0);
        tick();
        chk("ab_late2", b32.resp_valid, 0);
        b32.mem_rvalid = 1'b0;
        do_load(0, "ab_next", 32'h300, 3'b010, 64'hCAFEF00D, 0, 1,
                64'hCAFEF00D, 0, 3, 1, 32'h300, 0);

        // 64-bit build.
        do_load(1, "ld", 32'h10, 3'b011, 64'h8877665544332211, 0, 1,
                64'h8877665544332211, 0, 3, 1, 32'h10, 0);
        do_load(1, "lw64", 32'h14, 3'b010, 64'h8877665544332211, 0, 1,
                64'hFFFFFFFF88776655, 0, 3, 1, 32'h10, 0);
        do_load(1, "lwu64", 32'h14, 3'b110, 64'h8877665544332211, 0, 2,
                64'h0000000088776655, 0, 4, 1, 32'h10, 0);
        do_load(1, "lb64", 32'h17, 3'b000, 64'h8877665544332211, 0, 1,
                64'hFFFFFFFFFFFFFF88, 0, 3, 1, 32'h10, 0);
`ifdef LOAD_MISALIGNED_SPLIT_EN
        do_load(1, "ldwrap", 32'hFFFFFFFC, 3'b011, 64'h8877665544332211,
                64'h00FFEEDDCCBBAA99, 1, 64'hCCBBAA9988776655, 0, 5, 2,
                32'hFFFFFFF8, 32'h0);
`else
        do_load(1, "ldwrap", 32'hFFFFFFFC, 3'b011, 64'h8877665544332211,
                64'h00FFEEDDCCBBAA99, 1, 0, 1, 1, 0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/load_align_unit.md
# load_align_unit

Parametrised, sequential load-data alignment and extension unit for the rv32i datapath, and the multi-cycle successor to the combinational sign/zero extender. It accepts one load request (byte address + funct3), issues one or two aligned word reads to data memory over a valid/response handshake, merges the beats when an access straddles a word boundary, and returns the sign- or zero-extended result. It sits between the execute-stage address output and the writeback mux.

## Interface
- `XLEN`, 32: data width in bits; legal values are 32 or 64.
- `ADDR_W`, 32: byte-address width.
- `clk`  in  1  clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  a load request is present.
- `req_ready`  out  1  unit is idle and can accept a request.
- `req_addr`  in  ADDR_W  byte address of the load.
- `req_funct3`  in  3  RISC-V load funct3.
- `mem_req`  out  1  read strobe to memory; asserted for exactly one cycle per beat.
- `mem_addr`  out  ADDR_W  aligned read address; the low log2(XLEN/8) bits are always 0.
- `mem_rvalid`  in  1  read data is valid.
- `mem_rdata`  in  XLEN  read data.
- `resp_valid`  out  1  result is valid; one-cycle pulse.
- `resp_data`  out  XLEN  extended load result.
- `resp_err`  out  1  request was illegal or misaligned; qualified by `resp_valid`.

## Operation
- **Size decode:**
  - funct3[1:0] = 00 is 1 byte, 01 is 2, 10 is 4, 11 is 8 (8 is legal only when XLEN = 64).
  - funct3[2] = 1 selects zero-extension.
  - Legal funct3 values: 000, 001, 010, 100, 101. XLEN = 64 also allows 011 and 110. Any other value is an error.
- **Address terms:**
  - off = req_addr[log2(XLEN/8)-1:0]; base = req_addr with the off bits cleared.
  - cross = (off + size > XLEN/8).
- **FSM states:** IDLE, RD0, RD1, RESP.
  - IDLE: `req_ready` = 1. On `req_valid`, the request, off, size and cross are latched.
    - Illegal funct3 goes to RESP with err = 1.
    - Otherwise the unit goes to RD0 with `mem_addr` = base.
  - RD0: `mem_req` is high in the first cycle only. On `mem_rvalid` the unit captures lo = `mem_rdata`.
    - If cross, it goes to RD1 with `mem_addr` = base + XLEN/8, wrapping modulo 2^ADDR_W.
    - Otherwise it goes to RESP.
  - RD1: `mem_req` is high in the first cycle only. On `mem_rvalid` the unit captures hi and goes to RESP.
  - RESP: `resp_valid` = 1 for one cycle, then the unit returns to IDLE.
- **Merge and extend:**
  - Form the 2·XLEN value {hi, lo}; hi = 0 when the access does not cross.
  - Shift it right by off·8 and keep the low size·8 bits.
  - Extend to XLEN: replicate the top kept bit when funct3[2] = 0; fill with zeros otherwise.
  - Full-width loads (lw at XLEN = 32, ld at XLEN = 64) pass through unchanged.
- **Error responses:** `resp_data` = 0 whenever `resp_err` = 1.
- **Response ordering:** `mem_rvalid` is sampled only in RD0/RD1, and never in the same cycle as `mem_req`. A stray `mem_rvalid` in IDLE or RESP is ignored.

## Timing
- **Reset values:** all outputs are 0 and the FSM is in IDLE (`req_ready` rises to 1 the first cycle after reset deasserts). Captured lo/hi are cleared to 0.
- **Reset mid-operation:** immediate abort to IDLE. No `resp_valid` is produced for the aborted request.
- **Cycle latencies**, request accepted at cycle T:
  - `mem_req` at T+1.
  - With `mem_rvalid` arriving k ≥ 1 cycles after `mem_req`, the aligned case gives `resp_valid` at T+1+k+1.
  - The split case gives `resp_valid` at T+1+k0+1+k1+1.
  - The minimum is T+3 aligned, T+5 split.
- **Error case:** `resp_valid` at T+1, with no `mem_req`.
- **Busy handling:** `req_ready` = 0 from T+1 until the cycle after RESP. `req_valid` while busy is ignored, not queued.
- **Register stability:** `mem_addr` is registered and stable from the `mem_req` cycle until the matching `mem_rvalid`. `resp_data`/`resp_err` are registered and valid only while `resp_valid` = 1.

## Configuration
- **`LOAD_MISALIGNED_SPLIT_EN` defined:** crossing accesses are split into two beats as described above.
- **Not defined:**
  - A crossing access takes IDLE → RESP with `resp_err` = 1, `resp_data` = 0, `resp_valid` at T+1, and no `mem_req`.
  - The RD1 state and hi register are not synthesised.
  - Aligned and non-crossing accesses are unaffected.

## Test plan
- **lb sign-extend:** XLEN = 32, addr 0x103, funct3 000, memory at word 0x100 returns 0x80AA_BBCC → one `mem_req` at 0x100, `resp_data` 0xFFFF_FF80, err 0, `resp_valid` at T+3.
- **lhu zero-extend:** addr 0x102, funct3 101, word 0x100 returns 0xBEEF_1234 → `resp_data` 0x0000_BEEF.
- **lw split (macro on):** addr 0x1FE, word 0x1FC returns 0x2211_xxxx and word 0x200 returns 0xxxxx_4433 → two `mem_req`s at 0x1FC then 0x200; `resp_data` 0x4433_2211; `resp_valid` at T+5. With the macro off → err 1 at T+1, no `mem_req`.
- **Wrap and XLEN = 64:** XLEN = 64, ADDR_W = 32, addr 0xFFFF_FFFC, ld (011) → beats at 0xFFFF_FFF8 then 0x0000_0000; result is the upper 4 bytes of beat 0 as low half, lower 4 bytes of beat 1 as high half.
- **Illegal funct3 and backpressure:** funct3 111 → err at T+1, `resp_data` 0. A second `req_valid` held during a busy read is not accepted until `req_ready` = 1, then is processed normally. A stray `mem_rvalid` in IDLE produces no response.
- **Reset mid-operation:** reset asserted in RD0 while awaiting `mem_rvalid` → outputs 0 and `req_ready` = 1 after release; a late `mem_rvalid` is ignored; the next request completes correctly.
